// File: rtl/mips_run_ctrl.sv
// Run controller for mips_top: holds the core in reset, lets it run to HALT_PC or a cycle budget,
// then reads every register through the ra3/rd3 debug port and streams them out over valid/ready.
module mips_run_ctrl #(
    parameter logic [31:0] HALT_PC    = 32'h58,
    parameter int          MAX_CYCLES = 1000,
    parameter int          RST_CYCLES = 2,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             core_rst,
    input  logic [31:0]      pc_current,
    input  logic             we_dm,
    output logic [4:0]       ra3,
    input  logic [31:0]      rd3,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic [4:0]       dump_idx,
    output logic [31:0]      dump_data,
    output logic             dump_last,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] store_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_RUN,
        S_DUMP_REQ,
        S_DUMP_OUT,
        S_DONE
    } state_t;

    localparam int              RC_W     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0] RST_LAST = RC_W'(RST_CYCLES - 1);
    localparam logic [31:0]     MAX_C    = 32'(MAX_CYCLES);

    state_t          state;
    logic [RC_W-1:0] rst_cnt;
    logic [31:0]     next_cycles;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Unsaturated view of the count after this RUN cycle, used for the budget test.
    assign next_cycles = 32'(cycle_count) + 32'd1;
    assign dump_last   = dump_valid && (dump_idx == 5'd31);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            core_rst    <= 1'b1;
            ra3         <= 5'd0;
            dump_valid  <= 1'b0;
            dump_data   <= 32'd0;
            dump_idx    <= 5'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
            store_count <= '0;
            rst_cnt     <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state       <= S_RESET;
                        core_rst    <= 1'b1;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        timeout     <= 1'b0;
                        cycle_count <= '0;
                        store_count <= '0;
                        dump_idx    <= 5'd0;
                        rst_cnt     <= '0;
                    end
                end
                S_RESET: begin
                    if (rst_cnt == RST_LAST) begin
                        state    <= S_RUN;
                        core_rst <= 1'b0;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (pc_current == HALT_PC) begin
                        state <= S_DUMP_REQ;
                        ra3   <= dump_idx;
                    end else begin
                        cycle_count <= sat_inc(cycle_count);
                        if (we_dm) begin
                            store_count <= sat_inc(store_count);
                        end
                        if (next_cycles >= MAX_C) begin
                            timeout <= 1'b1;
                            state   <= S_DUMP_REQ;
                            ra3     <= dump_idx;
                        end
                    end
                end
                // ra3 already points at dump_idx here, so rd3 has had a full cycle to settle.
                S_DUMP_REQ: begin
                    ra3        <= dump_idx;
                    dump_data  <= rd3;
                    dump_valid <= 1'b1;
                    state      <= S_DUMP_OUT;
                end
                S_DUMP_OUT: begin
                    if (dump_ready) begin
                        dump_valid <= 1'b0;
                        if (dump_idx == 5'd31) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            dump_idx <= dump_idx + 5'd1;
                            ra3      <= dump_idx + 5'd1;
                            state    <= S_DUMP_REQ;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Directed bench for mips_run_ctrl with a small behavioural core: pc steps by 4 out of reset,
// stores sit at fixed instruction slots and the register file holds a known pattern.
module tb_mips_run_ctrl;

    localparam logic [31:0] HALT = 32'h58;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        core_rst;
    logic [31:0] pc_current;
    logic        we_dm;
    logic [4:0]  ra3;
    logic [31:0] rd3;
    logic        dump_valid;
    logic        dump_ready = 1'b0;
    logic [4:0]  dump_idx;
    logic [31:0] dump_data;
    logic        dump_last;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [15:0] cycle_count;
    logic [15:0] store_count;

    int checks = 0;
    int errors = 0;

    logic        loop_mode = 1'b0;
    logic [31:0] pc;
    logic [31:0] regs [32];
    logic [31:0] store_mask = 32'h0004_1088;

    logic [4:0]  beat_idx  [64];
    logic [31:0] beat_data [64];
    logic        beat_last [64];
    int          nbeats;
    int          unstable;
    int          last_bad;
    int          dump_cycles;

    mips_run_ctrl #(
        .HALT_PC   (32'h58),
        .MAX_CYCLES(50),
        .RST_CYCLES(2),
        .CNT_W     (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .core_rst   (core_rst),
        .pc_current (pc_current),
        .we_dm      (we_dm),
        .ra3        (ra3),
        .rd3        (rd3),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .dump_last  (dump_last),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .cycle_count(cycle_count),
        .store_count(store_count)
    );

    always #5 clk = ~clk;

    // Straight-line program ends in a self-loop at HALT; loop mode branches 0x40 -> 0x0 forever.
    always @(posedge clk) begin
        if (core_rst) pc <= 32'h0;
        else if (loop_mode) pc <= (pc == 32'h40) ? 32'h0 : pc + 32'd4;
        else if (pc != HALT) pc <= pc + 32'd4;
    end

    assign pc_current = pc;
    assign we_dm      = !core_rst && store_mask[pc[6:2]];
    assign rd3        = regs[ra3];

    function automatic logic [31:0] exp_reg(input int i);
        return (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i) * 32'h0001_0203;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic collect_dump(input bit rnd, input int budget);
        logic [4:0]  hold_idx;
        logic [31:0] hold_data;
        bit          stalled;
        nbeats = 0; unstable = 0; last_bad = 0; dump_cycles = 0; stalled = 0;
        hold_idx = 5'd0; hold_data = 32'd0;
        for (int i = 0; i < 64; i++) begin
            beat_idx[i] = 5'bx; beat_data[i] = 32'bx; beat_last[i] = 1'bx;
        end
        for (int c = 0; c < budget; c++) begin
            if (done === 1'b1) break;
            dump_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (dump_last !== (dump_valid && dump_idx == 5'd31)) last_bad++;
            if (dump_valid === 1'b1 && stalled && (dump_idx !== hold_idx || dump_data !== hold_data))
                unstable++;
            if (dump_valid === 1'b1) begin
                if (dump_ready) begin
                    if (nbeats < 64) begin
                        beat_idx[nbeats]  = dump_idx;
                        beat_data[nbeats] = dump_data;
                        beat_last[nbeats] = dump_last;
                    end
                    nbeats++;
                    stalled = 0;
                end else begin
                    stalled   = 1;
                    hold_idx  = dump_idx;
                    hold_data = dump_data;
                end
            end
            tick();
            dump_cycles++;
        end
        dump_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1;
        tick(); tick();
        checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL reset_core_rst got %b want 1", core_rst); end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL reset_flags got busy %b done %b timeout %b want 0 0 0", busy, done, timeout); end
        checks++; if (dump_valid !== 1'b0 || dump_idx !== 5'd0 || dump_data !== 32'd0 || ra3 !== 5'd0) begin errors++; $display("FAIL reset_dump got valid %b idx %0d data %0h ra3 %0d want 0 0 0 0", dump_valid, dump_idx, dump_data, ra3); end
        checks++; if (cycle_count !== 16'd0 || store_count !== 16'd0) begin errors++; $display("FAIL reset_counts got %0d %0d want 0 0", cycle_count, store_count); end
        rst = 1'b0; start = 1'b0;
        tick();
        checks++; if (busy !== 1'b0 || core_rst !== 1'b1) begin errors++; $display("FAIL reset_start_ignored got busy %b core_rst %b want 0 1", busy, core_rst); end
    endtask

    task automatic test_halt_run();
        int n;
        loop_mode = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (core_rst === 1'b1 && n < 10) begin n++; tick(); end
        checks++; if (n != 2) begin errors++; $display("FAIL core_rst_cycles got %0d want 2", n); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL run_busy got %b want 1", busy); end
        n = 0;
        while (!(pc_current == HALT && core_rst === 1'b0) && n < 200) begin n++; tick(); end
        checks++; if (n >= 200) begin errors++; $display("FAIL halt_wait got timeout want halt"); end
        checks++; if (cycle_count !== 16'd22) begin errors++; $display("FAIL halt_cycle_count got %0d want 22", cycle_count); end
        checks++; if (store_count !== 16'd4) begin errors++; $display("FAIL halt_store_count got %0d want 4", store_count); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL halt_timeout got %b want 0", timeout); end
    endtask

    task automatic test_dump_ready_high();
        tick();
        collect_dump(1'b0, 200);
        checks++; if (dump_cycles != 64 || done !== 1'b1) begin errors++; $display("FAIL dump_to_done got %0d cycles done %b want 64 1", dump_cycles, done); end
        checks++; if (nbeats != 32) begin errors++; $display("FAIL dump_beats got %0d want 32", nbeats); end
        checks++; if (last_bad != 0) begin errors++; $display("FAIL dump_last_flag got %0d bad cycles want 0", last_bad); end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (beat_idx[i] !== 5'(i) || beat_data[i] !== exp_reg(i) || beat_last[i] !== (i == 31)) begin
                errors++;
                $display("FAIL dump_beat%0d got idx %0d data %0h last %b want idx %0d data %0h last %b",
                         i, beat_idx[i], beat_data[i], beat_last[i], i, exp_reg(i), (i == 31));
            end
        end
        checks++; if (busy !== 1'b0 || core_rst !== 1'b0 || cycle_count !== 16'd22) begin errors++; $display("FAIL done_state got busy %b core_rst %b count %0d want 0 0 22", busy, core_rst, cycle_count); end
    endtask

    task automatic test_backpressure();
        loop_mode = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        collect_dump(1'b1, 2000);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_done got %b want 1", done); end
        checks++; if (nbeats != 32) begin errors++; $display("FAIL bp_beats got %0d want 32", nbeats); end
        checks++; if (unstable != 0) begin errors++; $display("FAIL bp_stable got %0d changes want 0", unstable); end
        checks++; if (cycle_count !== 16'd22 || store_count !== 16'd4) begin errors++; $display("FAIL bp_counts got %0d %0d want 22 4", cycle_count, store_count); end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (beat_idx[i] !== 5'(i) || beat_data[i] !== exp_reg(i) || beat_last[i] !== (i == 31)) begin
                errors++;
                $display("FAIL bp_beat%0d got idx %0d data %0h last %b want idx %0d data %0h", i, beat_idx[i], beat_data[i], beat_last[i], i, exp_reg(i));
            end
        end
    endtask

    task automatic test_timeout();
        loop_mode = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        collect_dump(1'b0, 400);
        checks++; if (done !== 1'b1 || timeout !== 1'b1) begin errors++; $display("FAIL to_flags got done %b timeout %b want 1 1", done, timeout); end
        checks++; if (cycle_count !== 16'd50) begin errors++; $display("FAIL to_cycle_count got %0d want 50", cycle_count); end
        checks++; if (store_count !== 16'd9) begin errors++; $display("FAIL to_store_count got %0d want 9", store_count); end
        checks++; if (nbeats != 32) begin errors++; $display("FAIL to_beats got %0d want 32", nbeats); end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (beat_idx[i] !== 5'(i) || beat_data[i] !== exp_reg(i) || beat_last[i] !== (i == 31)) begin
                errors++;
                $display("FAIL to_beat%0d got idx %0d data %0h want idx %0d data %0h", i, beat_idx[i], beat_data[i], i, exp_reg(i));
            end
        end
        loop_mode = 1'b0;
    endtask

    task automatic test_rst_mid_run();
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        checks++; if (core_rst !== 1'b0 || cycle_count === 16'd0) begin errors++; $display("FAIL mr_running got core_rst %b count %0d want 0 nonzero", core_rst, cycle_count); end
        rst = 1'b1; tick();
        checks++; if (core_rst !== 1'b1 || busy !== 1'b0 || dump_valid !== 1'b0) begin errors++; $display("FAIL mr_state got core_rst %b busy %b valid %b want 1 0 0", core_rst, busy, dump_valid); end
        checks++; if (cycle_count !== 16'd0 || store_count !== 16'd0 || timeout !== 1'b0) begin errors++; $display("FAIL mr_counts got %0d %0d %b want 0 0 0", cycle_count, store_count, timeout); end
        rst = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        checks++; if (dump_valid !== 1'b0 || busy !== 1'b0 || core_rst !== 1'b1) begin errors++; $display("FAIL mr_idle got valid %b busy %b core_rst %b want 0 0 1", dump_valid, busy, core_rst); end
    endtask

    task automatic test_rst_mid_dump();
        int n;
        dump_ready = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (dump_valid !== 1'b1 && n < 200) begin n++; tick(); end
        checks++; if (dump_valid !== 1'b1 || cycle_count !== 16'd22) begin errors++; $display("FAIL md_reach got valid %b count %0d want 1 22", dump_valid, cycle_count); end
        rst = 1'b1; tick();
        checks++; if (core_rst !== 1'b1 || busy !== 1'b0 || dump_valid !== 1'b0 || dump_idx !== 5'd0) begin errors++; $display("FAIL md_state got core_rst %b busy %b valid %b idx %0d want 1 0 0 0", core_rst, busy, dump_valid, dump_idx); end
        checks++; if (cycle_count !== 16'd0 || store_count !== 16'd0) begin errors++; $display("FAIL md_counts got %0d %0d want 0 0", cycle_count, store_count); end
        rst = 1'b0; tick();
        checks++; if (dump_valid !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL md_idle got valid %b done %b want 0 0", dump_valid, done); end
    endtask

    task automatic test_start_ignored_rerun();
        int n;
        logic [15:0] c1, s1;
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (core_rst === 1'b1 && n < 10) begin n++; tick(); end
        tick(); tick(); tick();
        start = 1'b1; tick(); start = 1'b0;
        checks++; if (core_rst !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL busy_start got core_rst %b busy %b want 0 1", core_rst, busy); end
        collect_dump(1'b0, 300);
        c1 = cycle_count; s1 = store_count;
        checks++; if (c1 !== 16'd22 || s1 !== 16'd4 || nbeats != 32) begin errors++; $display("FAIL run1 got %0d %0d beats %0d want 22 4 32", c1, s1, nbeats); end
        start = 1'b1; tick(); start = 1'b0;
        checks++; if (done !== 1'b0 || busy !== 1'b1 || core_rst !== 1'b1 || cycle_count !== 16'd0) begin errors++; $display("FAIL rerun_start got done %b busy %b core_rst %b count %0d want 0 1 1 0", done, busy, core_rst, cycle_count); end
        collect_dump(1'b0, 300);
        checks++; if (done !== 1'b1 || cycle_count !== c1 || store_count !== s1 || cycle_count !== 16'd22) begin errors++; $display("FAIL rerun_counts got %0d %0d done %b want 22 4 1", cycle_count, store_count, done); end
        checks++; if (nbeats != 32) begin errors++; $display("FAIL rerun_beats got %0d want 32", nbeats); end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (beat_idx[i] !== 5'(i) || beat_data[i] !== exp_reg(i)) begin
                errors++;
                $display("FAIL rerun_beat%0d got idx %0d data %0h want idx %0d data %0h", i, beat_idx[i], beat_data[i], i, exp_reg(i));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = exp_reg(i);
        test_reset();
        test_halt_run();
        test_dump_ready_high();
        test_backpressure();
        test_timeout();
        test_rst_mid_run();
        test_rst_mid_dump();
        test_start_ignored_rerun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
